mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request sequencer sitting directly upstream of the 256×8 level-sensitive memory block. Accepts single-word read/write requests over a valid/ready handshake, drives the memory's address, data and read/write enables with stable, non-overlapping timing, waits a configurable read latency, and returns one response pulse per request. Only one request is in flight at a time.

## Interface
- ADDR_LEN, 8, address width; matches the memory.
- WORD_LEN, 8, data word width; matches the memory.
- RD_WAIT, 1, cycles `mem_r_en` is held before `mem_rdata` is sampled; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_LEN  request address.
- req_wdata  in  WORD_LEN  write data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_data  out  WORD_LEN  read word for reads, 0 for writes.
- rsp_err  out  1  write-verify mismatch; valid only with `rsp_valid`.
- mem_addr  out  ADDR_LEN  to memory `addr`.
- mem_r_en  out  1  to memory `r_en`.
- mem_w_en  out  1  to memory `w_en`.
- mem_wdata  out  WORD_LEN  to memory `data_in`.
- mem_rdata  in  WORD_LEN  from memory `data_out`.

## Operation
- States: IDLE, WRITE, READ, VERIFY (macro only), DONE.
- IDLE: `req_ready`=1. Handshake = `req_valid && req_ready` at rising edge; latch `req_we`/`req_addr`/`req_wdata` into `mem_addr`/`mem_wdata` registers; go WRITE if `req_we`, else READ.
- WRITE: exactly 1 cycle, `mem_w_en`=1. Next: VERIFY if macro defined, else DONE.
- READ: `mem_r_en`=1 for RD_WAIT cycles (4-bit down-counter loaded with RD_WAIT-1). On the edge ending the last READ cycle, capture `mem_rdata` into `rsp_data`; go DONE.
- DONE: 1 cycle, `rsp_valid`=1; `rsp_data` as captured (0 for writes); return to IDLE.
- All outputs driven from flops. `mem_r_en` and `mem_w_en` never both 1. `mem_addr`/`mem_wdata` change only on an accepted handshake and hold until the next one.
- `req_*` inputs ignored outside IDLE.

## Timing
- Reset (async assert): state IDLE; `req_ready`, `rsp_valid`, `rsp_err`, `mem_r_en`, `mem_w_en` = 0; `rsp_data`, `mem_addr`, `mem_wdata` = 0; counter = 0. `req_ready` rises in the first cycle after deassertion.
- Handshake at edge k (k ≥ 0). Write without verify: WRITE cycle k+1, `rsp_valid` cycle k+2, `req_ready` cycle k+3.
- Read: `mem_r_en` cycles k+1..k+RD_WAIT, `rsp_valid` cycle k+RD_WAIT+1, `req_ready` cycle k+RD_WAIT+2.
- Throughput: at most one request per (latency+1) cycles; back-to-back `req_valid` held high is accepted in the first IDLE cycle.
- Reset mid-operation: enables drop immediately; no `rsp_valid` is issued for the aborted request; the memory word may or may not be written if reset hits during WRITE.
- Address wrap: none; full `ADDR_LEN` range, address 255 legal.

## Configuration
- `MEM_REQ_CTRL_VERIFY_EN` defined: after WRITE, enter VERIFY and hold `mem_r_en`=1 for RD_WAIT cycles, then compare `mem_rdata` with latched `mem_wdata`. `rsp_err`=1 in DONE on mismatch; `rsp_data` stays 0. Write latency becomes RD_WAIT+2 cycles to `rsp_valid`.
- Not defined: VERIFY state and comparator are absent; `rsp_err` is tied to 0.

## Test plan
- Reset with all inputs 0, release -> all outputs 0 during reset; `req_ready`=1 next cycle.
- Write 0xA5 to addr 0x10, then read addr 0x10 (RD_WAIT=1) -> `mem_w_en` high for exactly 1 cycle; read `rsp_valid` 2 cycles after handshake with `rsp_data`=0xA5.
- RD_WAIT=3, read addr 0xFF preloaded 0x3C -> `mem_r_en` high 3 cycles, `rsp_data`=0x3C at cycle k+4; `mem_r_en`&`mem_w_en` never 1.
- `req_valid` held high over 4 alternating write/read requests -> each accepted only in IDLE; changing `req_addr` mid-operation does not change `mem_addr`.
- Assert `rst` during READ cycle -> `mem_r_en`=0 immediately, no `rsp_valid`, next request after release completes normally.
- With `MEM_REQ_CTRL_VERIFY_EN`, force memory read data to 0x00 after writing 0x5A -> `rsp_err`=1 with `rsp_valid`; unforced write -> `rsp_err`=0.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Single-outstanding request sequencer in front of a 256x8 level-sensitive memory.
// Optional write-verify readback is enabled by defining MEM_REQ_CTRL_VERIFY_EN.
module mem_req_ctrl #(
    parameter int ADDR_LEN = 8,
    parameter int WORD_LEN = 8,
    parameter int RD_WAIT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [WORD_LEN-1:0] rsp_data,
    output logic                rsp_err,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
`ifdef MEM_REQ_CTRL_VERIFY_EN
    localparam logic [2:0] S_VERIFY = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;

    // Counter runs RD_WAIT-1 .. 0, so r_en stays high for exactly RD_WAIT cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);

    logic [2:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WORD_LEN-1:0] rsp_data_q, rsp_data_d;
    logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic                mem_r_en_q, mem_r_en_d;
    logic                mem_w_en_q, mem_w_en_d;
`ifdef MEM_REQ_CTRL_VERIFY_EN
    logic                rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_r_en_d  = mem_r_en_q;
        mem_w_en_d  = 1'b0;
`ifdef MEM_REQ_CTRL_VERIFY_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    rsp_data_d  = '0;
`ifdef MEM_REQ_CTRL_VERIFY_EN
                    rsp_err_d   = 1'b0;
`endif
                    if (req_we) begin
                        state_d    = S_WRITE;
                        mem_w_en_d = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        mem_r_en_d = 1'b1;
                        cnt_d      = WAIT_LOAD;
                    end
                end
            end
            S_WRITE: begin
`ifdef MEM_REQ_CTRL_VERIFY_EN
                state_d    = S_VERIFY;
                mem_r_en_d = 1'b1;
                cnt_d      = WAIT_LOAD;
`else
                state_d     = S_DONE;
                rsp_valid_d = 1'b1;
`endif
            end
            S_READ: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = mem_rdata;
                    mem_r_en_d  = 1'b0;
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef MEM_REQ_CTRL_VERIFY_EN
            S_VERIFY: begin
                if (cnt_q == 4'd0) begin
                    rsp_err_d   = (mem_rdata != mem_wdata_q);
                    mem_r_en_d  = 1'b0;
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            S_DONE: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
`ifdef MEM_REQ_CTRL_VERIFY_EN
                rsp_err_d   = 1'b0;
`endif
            end
            default: begin
                state_d     = S_IDLE;
                mem_r_en_d  = 1'b0;
                req_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
`ifdef MEM_REQ_CTRL_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
`ifdef MEM_REQ_CTRL_VERIFY_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_r_en  = mem_r_en_q;
    assign mem_w_en  = mem_w_en_q;
`ifdef MEM_REQ_CTRL_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench: two controllers (RD_WAIT=1 and RD_WAIT=3), each with its own memory model.
module tb_mem_req_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid [2];
    logic [7:0] rsp_data  [2];
    logic       rsp_err   [2];
    logic [7:0] mem_addr  [2];
    logic       mem_r_en  [2];
    logic       mem_w_en  [2];
    logic [7:0] mem_wdata [2];
    logic [7:0] mem_rdata [2];
    logic       force_zero [2];

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int total = 0;
    int bad   = 0;

    mem_req_ctrl #(.ADDR_LEN(8), .WORD_LEN(8), .RD_WAIT(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .mem_addr(mem_addr[0]), .mem_r_en(mem_r_en[0]), .mem_w_en(mem_w_en[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_req_ctrl #(.ADDR_LEN(8), .WORD_LEN(8), .RD_WAIT(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .mem_addr(mem_addr[1]), .mem_r_en(mem_r_en[1]), .mem_w_en(mem_w_en[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w_en[0]) mem0[mem_addr[0]] <= mem_wdata[0];
        if (mem_w_en[1]) mem1[mem_addr[1]] <= mem_wdata[1];
    end

    always_comb begin
        mem_rdata[0] = 8'h00;
        mem_rdata[1] = 8'h00;
        if (mem_r_en[0] && !force_zero[0]) mem_rdata[0] = mem0[mem_addr[0]];
        if (mem_r_en[1] && !force_zero[1]) mem_rdata[1] = mem1[mem_addr[1]];
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Read and write enables must never overlap on either controller.
    always @(negedge clk) begin
        if (!rst) begin
            chk1("excl0", mem_r_en[0] & mem_w_en[0], 1'b0);
            chk1("excl1", mem_r_en[1] & mem_w_en[1], 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (!req_ready[d] && n < 50) begin
            step();
            n++;
        end
        chk1("ready_wait", req_ready[d], 1'b1);
    endtask

    task automatic do_req(input int d, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_data,
                          input logic exp_err);
        int rw = (d == 0) ? 1 : 3;
        wait_ready(d);
        req_valid[d] = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        step();
        req_valid[d] = 1'b0;
        chk8("hs_addr", mem_addr[d], addr);
        chk8("hs_wdata", mem_wdata[d], wdata);
        chk1("hs_ready", req_ready[d], 1'b0);
        if (we) begin
            chk1("wr_wen", mem_w_en[d], 1'b1);
            chk1("wr_ren", mem_r_en[d], 1'b0);
            chk1("wr_rspv", rsp_valid[d], 1'b0);
            step();
`ifdef MEM_REQ_CTRL_VERIFY_EN
            for (int i = 0; i < rw; i++) begin
                chk1("vf_ren", mem_r_en[d], 1'b1);
                chk1("vf_wen", mem_w_en[d], 1'b0);
                chk1("vf_rspv", rsp_valid[d], 1'b0);
                step();
            end
`endif
        end else begin
            for (int i = 0; i < rw; i++) begin
                chk1("rd_ren", mem_r_en[d], 1'b1);
                chk1("rd_wen", mem_w_en[d], 1'b0);
                chk1("rd_rspv", rsp_valid[d], 1'b0);
                chk1("rd_ready", req_ready[d], 1'b0);
                step();
            end
        end
        chk1("done_rspv", rsp_valid[d], 1'b1);
        chk8("done_data", rsp_data[d], exp_data);
        chk1("done_err", rsp_err[d], exp_err);
        chk1("done_ren", mem_r_en[d], 1'b0);
        chk1("done_wen", mem_w_en[d], 1'b0);
        chk1("done_ready", req_ready[d], 1'b0);
        step();
        chk1("post_rspv", rsp_valid[d], 1'b0);
        chk1("post_ready", req_ready[d], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b_addr [4];
        logic [7:0] b_data [4];
        logic [7:0] b_exp  [4];
        int         cyc;
        int         lat;
        logic       got;
        logic       we_n;

        b_addr = '{8'h20, 8'h20, 8'hFF, 8'hFF};
        b_data = '{8'h11, 8'h00, 8'h77, 8'h00};
        b_exp  = '{8'h00, 8'h11, 8'h00, 8'h77};
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        rst = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        force_zero[0] = 1'b0;
        force_zero[1] = 1'b0;
        req_we = 1'b0;
        req_addr = 8'h00;
        req_wdata = 8'h00;

        // Reset state on both controllers.
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk1("rst_ready", req_ready[d], 1'b0);
            chk1("rst_rspv", rsp_valid[d], 1'b0);
            chk1("rst_err", rsp_err[d], 1'b0);
            chk1("rst_ren", mem_r_en[d], 1'b0);
            chk1("rst_wen", mem_w_en[d], 1'b0);
            chk8("rst_data", rsp_data[d], 8'h00);
            chk8("rst_addr", mem_addr[d], 8'h00);
            chk8("rst_wdata", mem_wdata[d], 8'h00);
        end
        rst = 1'b0;
        #1;
        chk1("rel_ready0", req_ready[0], 1'b0);
        step();
        chk1("rel_ready0_next", req_ready[0], 1'b1);
        chk1("rel_ready1_next", req_ready[1], 1'b1);

        // Write then read back, RD_WAIT=1.
        do_req(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
        do_req(0, 1'b0, 8'h10, 8'h3E, 8'hA5, 1'b0);

        // RD_WAIT=3, top address, preloaded word.
        mem1[255] = 8'h3C;
        do_req(1, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0);

        // Write to address 255 on the RD_WAIT=1 controller; rsp_data must clear to 0.
        do_req(0, 1'b1, 8'hFF, 8'h5A, 8'h00, 1'b0);
        chk8("mem_ff", mem0[255], 8'h5A);

        // req_valid held high across alternating write/read requests.
        wait_ready(0);
        req_valid[0] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            we_n      = (n % 2 == 0);
            req_we    = we_n;
            req_addr  = b_addr[n];
            req_wdata = b_data[n];
            step();
            chk8("b2b_addr", mem_addr[0], b_addr[n]);
            chk1("b2b_busy", req_ready[0], 1'b0);
            cyc = 1;
            got = 1'b0;
            while (!req_ready[0] && cyc < 20) begin
                if (rsp_valid[0]) begin
                    chk8("b2b_data", rsp_data[0], b_exp[n]);
                    got = 1'b1;
                end
                req_addr  = ~b_addr[n];
                req_we    = ~we_n;
                req_wdata = 8'hEE;
                step();
                cyc++;
                chk8("b2b_hold_addr", mem_addr[0], b_addr[n]);
                chk8("b2b_hold_wdata", mem_wdata[0], b_data[n]);
            end
            chk1("b2b_rsp_seen", got, 1'b1);
`ifdef MEM_REQ_CTRL_VERIFY_EN
            lat = we_n ? 4 : 3;
`else
            lat = 3;
`endif
            chk8("b2b_latency", 8'(cyc), 8'(lat));
        end
        req_valid[0] = 1'b0;

        // Reset asserted during a READ on the RD_WAIT=3 controller.
        wait_ready(1);
        req_valid[1] = 1'b1;
        req_we       = 1'b0;
        req_addr     = 8'h42;
        req_wdata    = 8'h00;
        step();
        req_valid[1] = 1'b0;
        chk1("abort_ren_a", mem_r_en[1], 1'b1);
        step();
        chk1("abort_ren_b", mem_r_en[1], 1'b1);
        rst = 1'b1;
        #1;
        chk1("abort_ren_drop", mem_r_en[1], 1'b0);
        chk1("abort_rspv", rsp_valid[1], 1'b0);
        chk1("abort_ready", req_ready[1], 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("abort_no_rsp", rsp_valid[1], 1'b0);
        end
        mem1[8'h42] = 8'hC3;
        do_req(1, 1'b0, 8'h42, 8'h00, 8'hC3, 1'b0);
        do_req(1, 1'b1, 8'h43, 8'h96, 8'h00, 1'b0);
        chk8("mem1_43", mem1[8'h43], 8'h96);

`ifdef MEM_REQ_CTRL_VERIFY_EN
        force_zero[0] = 1'b1;
        do_req(0, 1'b1, 8'h33, 8'h5A, 8'h00, 1'b1);
        force_zero[0] = 1'b0;
        do_req(0, 1'b1, 8'h34, 8'h5A, 8'h00, 1'b0);
`else
        do_req(0, 1'b1, 8'h33, 8'h5A, 8'h00, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
